// File: rtl/mz_pkg.sv
// Shared types and default sizing for the mz range-zeroing memory.
// Consumers import this package; nothing here is synthesized on its own.
package mz_pkg;

  typedef enum logic {IDLE, ZERO} mz_state_t;

  localparam int DEF_ADDRWIDTH       = 8;
  localparam int DEF_DATAWIDTH       = 8;
  localparam int DEF_WORDS_PER_CYCLE = 4;

endpackage

// File: rtl/mz_mem.sv
// Register-array storage: one write port, WORDS_PER_CYCLE zero-write lanes, async read.
// Writes land on posedge, read is combinational; no backpressure (caller arbitrates ports).
module mz_mem
  import mz_pkg::*;
#(
  parameter int ADDRWIDTH       = DEF_ADDRWIDTH,
  parameter int DATAWIDTH       = DEF_DATAWIDTH,
  parameter int WORDS_PER_CYCLE = DEF_WORDS_PER_CYCLE
) (
  input  logic                       clock,
  input  logic                       we,
  input  logic [ADDRWIDTH-1:0]       addr,
  input  logic [DATAWIDTH-1:0]       din,
  input  logic [ADDRWIDTH-1:0]       zbase,
  input  logic [WORDS_PER_CYCLE-1:0] zen,
  output logic [DATAWIDTH-1:0]       dout
);

  localparam int DEPTH = 2 ** ADDRWIDTH;

  logic [DATAWIDTH-1:0] mem [DEPTH];
  logic [ADDRWIDTH-1:0] zaddr [WORDS_PER_CYCLE];

  // Lane addresses may wrap past the top of the array only when their enable is low.
  for (genvar k = 0; k < WORDS_PER_CYCLE; k++) begin : g_zaddr
    assign zaddr[k] = zbase + ADDRWIDTH'(k);
  end

  always_ff @(posedge clock) begin
    if (we) mem[addr] <= din;
    for (int k = 0; k < WORDS_PER_CYCLE; k++) begin
      if (zen[k]) mem[zaddr[k]] <= '0;
    end
  end

  assign dout = mem[addr];

endmodule

// File: rtl/mz.sv
// Memory with a range-zeroing engine: clears [low, high] at WORDS_PER_CYCLE words per clock.
// Read is combinational; while busy all host writes, bound loads and zero requests are dropped.
module mz
  import mz_pkg::*;
#(
  parameter int ADDRWIDTH       = DEF_ADDRWIDTH,
  parameter int DATAWIDTH       = DEF_DATAWIDTH,
  parameter int WORDS_PER_CYCLE = DEF_WORDS_PER_CYCLE
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 ld_high,
  input  logic                 ld_low,
  input  logic [ADDRWIDTH-1:0] addr,
  input  logic [DATAWIDTH-1:0] din,
  input  logic                 write,
  input  logic                 zero,
  output logic [DATAWIDTH-1:0] dout,
  output logic                 busy
);

  localparam int PW = ADDRWIDTH + 1;

  mz_state_t            state, state_nxt;
  logic [ADDRWIDTH-1:0] low, low_nxt;
  logic [ADDRWIDTH-1:0] high, high_nxt;
  logic [PW-1:0]        ptr, ptr_nxt;
  logic [PW-1:0]        high_ext;
  logic                 mem_we;
  logic [WORDS_PER_CYCLE-1:0] zen;

  // One extra bit keeps ptr+k comparisons honest when high is all-ones.
  assign high_ext = {1'b0, high};

  always_comb begin
    state_nxt = state;
    ptr_nxt   = ptr;
    low_nxt   = low;
    high_nxt  = high;
    mem_we    = 1'b0;
    zen       = '0;
    case (state)
      IDLE: begin
        if (ld_high) high_nxt = addr;
        if (ld_low)  low_nxt  = addr;
        if (zero) begin
          if (low <= high) begin
            ptr_nxt   = {1'b0, low};
            state_nxt = ZERO;
          end
        end else if (write) begin
          mem_we = 1'b1;
        end
      end
      ZERO: begin
        for (int k = 0; k < WORDS_PER_CYCLE; k++) begin
          zen[k] = (ptr + PW'(k)) <= high_ext;
        end
        if ((ptr + PW'(WORDS_PER_CYCLE)) > high_ext) state_nxt = IDLE;
        else                                         ptr_nxt   = ptr + PW'(WORDS_PER_CYCLE);
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state <= IDLE;
      busy  <= 1'b0;
      low   <= '0;
      high  <= '1;
      ptr   <= '0;
    end else begin
      state <= state_nxt;
      busy  <= (state_nxt == ZERO);
      low   <= low_nxt;
      high  <= high_nxt;
      ptr   <= ptr_nxt;
    end
  end

  // Reset aborts at once: nothing is written on the edge that sees reset.
  mz_mem #(
    .ADDRWIDTH       (ADDRWIDTH),
    .DATAWIDTH       (DATAWIDTH),
    .WORDS_PER_CYCLE (WORDS_PER_CYCLE)
  ) u_mem (
    .clock (clock),
    .we    (mem_we & ~reset),
    .addr  (addr),
    .din   (din),
    .zbase (ptr[ADDRWIDTH-1:0]),
    .zen   (zen & {WORDS_PER_CYCLE{~reset}}),
    .dout  (dout)
  );

endmodule

// File: tb/tb_mz.sv
// Directed bench for mz: write/read, range zeroing latency, busy gating, empty range, reset abort.
module tb_mz;

  logic       clock;
  logic       reset;
  logic       ld_high;
  logic       ld_low;
  logic [7:0] addr;
  logic [7:0] din;
  logic       write;
  logic       zero;
  logic [7:0] dout;
  logic       busy;

  int checks = 0;
  int errors = 0;
  int n;

  mz dut (
    .clock   (clock),
    .reset   (reset),
    .ld_high (ld_high),
    .ld_low  (ld_low),
    .addr    (addr),
    .din     (din),
    .write   (write),
    .zero    (zero),
    .dout    (dout),
    .busy    (busy)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic do_write(input logic [7:0] a, input logic [7:0] d);
    addr = a; din = d; write = 1'b1;
    tick();
    write = 1'b0;
  endtask

  task automatic set_bounds(input logic [7:0] lo, input logic [7:0] hi);
    addr = lo; ld_low = 1'b1;
    tick();
    ld_low = 1'b0;
    addr = hi; ld_high = 1'b1;
    tick();
    ld_high = 1'b0;
  endtask

  task automatic start_zero();
    zero = 1'b1;
    tick();
    zero = 1'b0;
  endtask

  task automatic wait_idle(output int cnt);
    cnt = 0;
    while (busy && cnt < 300) begin
      tick();
      cnt++;
    end
  endtask

  task automatic rd(input string tag, input logic [7:0] a, input logic [7:0] exp);
    addr = a;
    #1;
    chk(tag, dout, exp);
  endtask

  initial begin
    reset = 1'b1; ld_high = 1'b0; ld_low = 1'b0; addr = '0; din = '0;
    write = 1'b0; zero = 1'b0;
    tick();
    tick();
    reset = 1'b0;
    chk("reset_busy", busy, 0);

    // 1: plain write then combinational read
    do_write(8'hAA, 8'h55);
    rd("t1_dout", 8'hAA, 8'h55);
    chk("t1_busy", busy, 0);

    // 2: full-range clear takes 64 edges
    do_write(8'h00, 8'h12);
    do_write(8'hFF, 8'h34);
    set_bounds(8'h00, 8'hFF);
    start_zero();
    chk("t2_busy_start", busy, 1);
    wait_idle(n);
    chk("t2_cycles", n, 64);
    chk("t2_busy_end", busy, 0);
    rd("t2_m00", 8'h00, 8'h00);
    rd("t2_m55", 8'h55, 8'h00);
    rd("t2_mFF", 8'hFF, 8'h00);
    rd("t2_mAA", 8'hAA, 8'h00);

    // 3: writes and bound loads while busy are dropped (0x33 already passed by ptr)
    start_zero();
    repeat (20) tick();
    addr = 8'h33; din = 8'h77; write = 1'b1; ld_high = 1'b1;
    tick();
    write = 1'b0; ld_high = 1'b0;
    wait_idle(n);
    chk("t3_busy_end", busy, 0);
    rd("t3_m33", 8'h33, 8'h00);
    // high must still be 0xFF: a new clear takes the full 64 edges
    start_zero();
    wait_idle(n);
    chk("t3_high_kept", n, 64);

    // 4: single-word range
    do_write(8'hA9, 8'hC9);
    do_write(8'hAA, 8'hBB);
    do_write(8'hAB, 8'hCB);
    set_bounds(8'hAA, 8'hAA);
    start_zero();
    chk("t4_busy_start", busy, 1);
    wait_idle(n);
    chk("t4_cycles", n, 1);
    rd("t4_mAA", 8'hAA, 8'h00);
    rd("t4_mA9", 8'hA9, 8'hC9);
    rd("t4_mAB", 8'hAB, 8'hCB);

    // 5: 16-word range, neighbours untouched
    do_write(8'h0F, 8'h0F);
    do_write(8'h10, 8'h11);
    do_write(8'h1F, 8'h22);
    do_write(8'h20, 8'h11);
    set_bounds(8'h10, 8'h1F);
    start_zero();
    wait_idle(n);
    chk("t5_cycles", n, 4);
    rd("t5_m10", 8'h10, 8'h00);
    rd("t5_m1F", 8'h1F, 8'h00);
    rd("t5_m20", 8'h20, 8'h11);
    rd("t5_m0F", 8'h0F, 8'h0F);

    // 6: empty range; the same-cycle write is still dropped
    do_write(8'h15, 8'h66);
    set_bounds(8'h20, 8'h10);
    addr = 8'h30; din = 8'h99; write = 1'b1; zero = 1'b1;
    tick();
    write = 1'b0; zero = 1'b0;
    chk("t6_busy", busy, 0);
    rd("t6_m30", 8'h30, 8'h00);
    rd("t6_m15", 8'h15, 8'h66);
    rd("t6_m20", 8'h20, 8'h11);

    // 6b: reset mid-clear aborts, uncleared words keep data
    do_write(8'h01, 8'h12);
    do_write(8'hF0, 8'hAB);
    set_bounds(8'h00, 8'hFF);
    start_zero();
    repeat (5) tick();
    chk("t6b_busy_pre", busy, 1);
    reset = 1'b1;
    tick();
    chk("t6b_busy_reset", busy, 0);
    reset = 1'b0;
    tick();
    chk("t6b_busy_after", busy, 0);
    rd("t6b_m01", 8'h01, 8'h00);
    rd("t6b_mF0", 8'hF0, 8'hAB);
    // reset restores default bounds 0x00..0xFF
    start_zero();
    wait_idle(n);
    chk("t6b_default_bounds", n, 64);
    rd("t6b_mF0_cleared", 8'hF0, 8'h00);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
